// File: rtl/sram_ctrl.sv
// sram_ctrl: blocking load/store controller between the pipeline memory stage
// and an asynchronous 32-bit SRAM; every access stalls the pipeline until done.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mem_access_read,
  input  logic        mem_access_write,
  input  logic [2:0]  mem_access_size,
  input  logic [31:0] mem_access_addr,
  input  logic [31:0] mem_access_data_out,
  output logic [31:0] mem_access_data_in,
  output logic        stall,
  output logic        alignment_err,
  output logic [19:0] sram_addr,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic [31:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [31:0] sram_dq_i
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_RECOVER = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [2:0] LEN_BYTE  = 3'd0;
  localparam logic [2:0] LEN_HALF  = 3'd1;
  localparam logic [2:0] LEN_WORD  = 3'd2;
  localparam logic [2:0] LEN_LEFT  = 3'd3;
  localparam logic [2:0] LEN_RIGHT = 3'd4;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  // Active-low byte enables for a given access size and byte offset.
  function automatic logic [3:0] byte_en_n(input logic [2:0] size, input logic [1:0] k);
    logic [3:0] en;
    case (size)
      LEN_BYTE:  en = 4'b0001 << k;
      LEN_HALF:  en = k[1] ? 4'b1100 : 4'b0011;
      LEN_WORD:  en = 4'b1111;
      LEN_LEFT:  en = 4'b1111 >> (2'd3 - k);
      LEN_RIGHT: en = 4'b1111 << k;
      default:   en = 4'b0000;
    endcase
    return ~en;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] k);
    return ((size == LEN_HALF) && k[0]) || ((size == LEN_WORD) && (k != 2'b00));
  endfunction

  logic [2:0]  state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [19:0] addr_r;
  logic [3:0]  be_lat_r, be_new_s, be_sel_s, be_nxt_s;
  logic [31:0] dq_r, data_in_r;
  logic        ce_n_r, oe_n_r, we_n_r, dq_oe_r, align_err_r;
  logic        ce_nxt_s, oe_nxt_s, we_nxt_s, dq_oe_nxt_s;
  logic        req_s, misaligned_s, accept_s, capture_s;
  logic        unused_addr_s;

  assign req_s         = mem_access_read | mem_access_write;
  assign misaligned_s  = is_misaligned(mem_access_size, mem_access_addr[1:0]);
  assign accept_s      = (state_r == ST_IDLE) & req_s & ~flush & ~misaligned_s & ~rst_n;
  assign be_new_s      = byte_en_n(mem_access_size, mem_access_addr[1:0]);
  assign be_sel_s      = accept_s ? be_new_s : be_lat_r;
  assign unused_addr_s = ^mem_access_addr[31:22];

  // Next state, wait counter and strobe levels for the state being entered.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = mem_access_write ? ST_WRITE : ST_READ;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = WAIT_LOAD;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = WAIT_LOAD;
          capture_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_WRITE: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RECOVER;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RECOVER: begin
        state_nxt_s = ST_DONE;
        cnt_nxt_s   = WAIT_LOAD;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = WAIT_LOAD;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = WAIT_LOAD;
      end
    endcase

    ce_nxt_s    = 1'b1;
    oe_nxt_s    = 1'b1;
    we_nxt_s    = 1'b1;
    dq_oe_nxt_s = 1'b0;
    be_nxt_s    = 4'b1111;
    case (state_nxt_s)
      ST_READ: begin
        ce_nxt_s = 1'b0;
        oe_nxt_s = 1'b0;
        be_nxt_s = 4'b0000;
      end
      ST_WRITE: begin
        ce_nxt_s    = 1'b0;
        we_nxt_s    = 1'b0;
        dq_oe_nxt_s = 1'b1;
        be_nxt_s    = be_sel_s;
      end
      ST_RECOVER: begin
        ce_nxt_s    = 1'b0;
        dq_oe_nxt_s = 1'b1;
        be_nxt_s    = be_sel_s;
      end
      default: begin
        ce_nxt_s = 1'b1;
      end
    endcase
  end

  // State, latched request and registered SRAM/pipeline outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= WAIT_LOAD;
      addr_r      <= 20'd0;
      be_lat_r    <= 4'b1111;
      dq_r        <= 32'd0;
      data_in_r   <= 32'd0;
      ce_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      sram_be_n   <= 4'b1111;
      dq_oe_r     <= 1'b0;
      align_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ce_n_r      <= ce_nxt_s;
      oe_n_r      <= oe_nxt_s;
      we_n_r      <= we_nxt_s;
      sram_be_n   <= be_nxt_s;
      dq_oe_r     <= dq_oe_nxt_s;
      align_err_r <= (state_r == ST_IDLE) & req_s & ~flush & misaligned_s;
      if (accept_s) begin
        addr_r   <= mem_access_addr[21:2];
        be_lat_r <= be_new_s;
        dq_r     <= mem_access_data_out;
      end
      if (capture_s) begin
        data_in_r <= sram_dq_i;
      end
    end
  end

  // The accept cycle stalls combinationally so the pipeline holds the request.
  assign stall = accept_s | (state_r == ST_READ) | (state_r == ST_WRITE) |
                 (state_r == ST_RECOVER);

  assign mem_access_data_in = data_in_r;
  assign alignment_err      = align_err_r;
  assign sram_addr          = addr_r;
  assign sram_ce_n          = ce_n_r;
  assign sram_oe_n          = oe_n_r;
  assign sram_we_n          = we_n_r;
  assign sram_dq_o          = dq_r;
  assign sram_dq_oe         = dq_oe_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized scoreboard bench for sram_ctrl with a behavioural
// SRAM on the bus and a byte-level reference memory model.
module tb_sram_ctrl;

  localparam int W = 2;
  localparam logic [2:0] LEN_BYTE  = 3'd0;
  localparam logic [2:0] LEN_HALF  = 3'd1;
  localparam logic [2:0] LEN_WORD  = 3'd2;
  localparam logic [2:0] LEN_LEFT  = 3'd3;
  localparam logic [2:0] LEN_RIGHT = 3'd4;
  localparam int K_RD = 0, K_WR = 1, K_AB = 2, K_MIS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        mem_access_read = 1'b0;
  logic        mem_access_write = 1'b0;
  logic [2:0]  mem_access_size = 3'd0;
  logic [31:0] mem_access_addr = 32'd0;
  logic [31:0] mem_access_data_out = 32'd0;
  logic [31:0] mem_access_data_in;
  logic        stall, alignment_err;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;
  logic [3:0]  sram_be_n;
  logic [31:0] sram_dq_o, sram_dq_i;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mem_access_read(mem_access_read), .mem_access_write(mem_access_write),
    .mem_access_size(mem_access_size), .mem_access_addr(mem_access_addr),
    .mem_access_data_out(mem_access_data_out), .mem_access_data_in(mem_access_data_in),
    .stall(stall), .alignment_err(alignment_err), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          stall_c, ce_c, oe_c, we_c, rec_c;
    logic [3:0]  be_n;
    logic [19:0] addr;
    logic [31:0] dq;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] sram_mem [0:15];
  logic [31:0] model_mem [0:15];
  logic [31:0] model_data = 32'd0;
  logic [31:0] junk_r = 32'h5A5A_A5A5;

  // Behavioural SRAM: drives stored data only while output-enabled.
  assign sram_dq_i = !sram_oe_n ? sram_mem[sram_addr[3:0]] : junk_r;
  always @(posedge clk) begin
    junk_r <= $urandom;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[3:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] be_model(input logic [2:0] size, input int k);
    logic [3:0] r;
    logic en;
    r = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      en = (size == LEN_BYTE && b == k) || (size == LEN_HALF && b / 2 == k / 2) ||
           (size == LEN_WORD) || (size == LEN_LEFT && b <= k) || (size == LEN_RIGHT && b >= k);
      if (en) r[b] = 1'b0;
    end
    return r;
  endfunction

  task automatic apply_write(input int idx, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (!be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // Monitor: accumulates each stalled window, scores it when stall drops.
  int          obs_stall, obs_ce, obs_oe, obs_we, obs_rec;
  logic [3:0]  obs_be;
  logic [19:0] obs_addr;
  logic [31:0] obs_dq;
  logic        obs_be_bad, obs_seen_ce, in_txn = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      in_txn = 1'b0;
    end else begin
      if (alignment_err) begin
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL align_unexpected: got alignment_err=1 expected no pending access");
        end else begin
          e = q.pop_front();
          chk("align_expected", 32'(alignment_err), 32'(e.kind == K_MIS));
          chk("align_stall", 32'(stall), 32'd0);
          chk("align_ce_n", 32'(sram_ce_n), 32'd1);
          chk("align_data", mem_access_data_in, e.data);
        end
      end
      if (stall) begin
        if (!in_txn) begin
          obs_stall = 0; obs_ce = 0; obs_oe = 0; obs_we = 0; obs_rec = 0;
          obs_be_bad = 1'b0; obs_seen_ce = 1'b0; obs_be = 4'b1111;
          obs_addr = 20'd0; obs_dq = 32'd0;
        end
        in_txn = 1'b1;
        obs_stall++;
        if (!sram_ce_n) begin
          obs_ce++;
          if (obs_seen_ce && sram_be_n !== obs_be) obs_be_bad = 1'b1;
          obs_be = sram_be_n; obs_addr = sram_addr; obs_seen_ce = 1'b1;
        end
        if (!sram_oe_n) obs_oe++;
        if (!sram_we_n) obs_we++;
        if (!sram_ce_n && sram_we_n && sram_dq_oe) obs_rec++;
        if (sram_dq_oe) obs_dq = sram_dq_o;
      end else if (in_txn) begin
        in_txn = 1'b0;
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL txn_unexpected: got stalled access expected none");
        end else begin
          e = q.pop_front();
          chk("stall_cycles", obs_stall, e.stall_c);
          chk("ce_cycles", obs_ce, e.ce_c);
          chk("oe_cycles", obs_oe, e.oe_c);
          chk("we_cycles", obs_we, e.we_c);
          chk("recover_cycles", obs_rec, e.rec_c);
          chk("be_n", 32'(obs_be), 32'(e.be_n));
          chk("be_stable", 32'(obs_be_bad), 32'd0);
          chk("sram_addr", 32'(obs_addr), 32'(e.addr));
          if (e.kind == K_WR) chk("dq_o", obs_dq, e.dq);
          chk("data_in", mem_access_data_in, e.data);
          chk("end_strobes", {24'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n},
              32'h0000_00EF);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_strobes"}, {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, alignment_err},
        32'h0000_001C);
    chk({tag, "_be_n"}, 32'(sram_be_n), 32'hF);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_dq_o"}, sram_dq_o, 32'd0);
    chk({tag, "_data_in"}, mem_access_data_in, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // fmode: 0 none, 1 flush in IDLE, 2 flush in first READ cycle, 3 flush during WRITE
  task automatic issue(input logic rd, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input int fmode);
    exp_t e;
    logic mis;
    int idx, n;
    idx = int'(addr[5:2]);
    mis = (size == LEN_HALF && addr[0]) || (size == LEN_WORD && addr[1:0] != 2'b00);
    e.kind = K_MIS; e.stall_c = 0; e.ce_c = 0; e.oe_c = 0; e.we_c = 0; e.rec_c = 0;
    e.be_n = 4'b0000; e.addr = addr[21:2]; e.dq = wdata; e.data = model_data;
    mem_access_read = rd; mem_access_write = wr; mem_access_size = size;
    mem_access_addr = addr; mem_access_data_out = wdata;
    if (fmode == 1) begin
      flush = 1'b1;
      #1 chk("flush_idle_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      mem_access_read = 1'b0; mem_access_write = 1'b0; flush = 1'b0;
      chk("flush_idle_ce_n", 32'(sram_ce_n), 32'd1);
      chk("flush_idle_err", 32'(alignment_err), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (mis) begin
      e.kind = K_MIS;
    end else if (wr) begin
      e.kind = K_WR; e.stall_c = W + 2; e.ce_c = W + 1; e.we_c = W; e.rec_c = 1;
      e.be_n = be_model(size, int'(addr[1:0]));
      apply_write(idx, e.be_n, wdata);
    end else if (fmode == 2) begin
      e.kind = K_AB; e.stall_c = 2; e.ce_c = 1; e.oe_c = 1;
    end else begin
      model_data = model_mem[idx];
      e.kind = K_RD; e.stall_c = W + 1; e.ce_c = W; e.oe_c = W; e.data = model_data;
    end
    q.push_back(e);
    @(posedge clk); #1;
    mem_access_read = 1'b0; mem_access_write = 1'b0;
    if (!mis && ((!wr && fmode == 2) || (wr && fmode == 3))) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    n = 0;
    while (stall && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      n_checks++; n_err++;
      $display("FAIL stall_timeout: got stall stuck high expected release within 40 cycles");
    end
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v, a;
    int sel, rd, wr, fm;
    logic [2:0] sz;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      model_mem[i] = v;
    end
    sram_mem[4] = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;

    // reset wins over a simultaneous request and flush
    mem_access_read = 1'b1; mem_access_addr = 32'h10; mem_access_size = LEN_WORD; flush = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; mem_access_read = 1'b0; flush = 1'b0;
    #3 check_reset_vals("reset");

    @(posedge clk); #1;
    issue(1'b1, 1'b0, LEN_WORD, 32'h0000_0010, 32'd0, 0);
    issue(1'b0, 1'b1, LEN_BYTE, 32'h0000_0007, 32'hABAB_ABAB, 0);
    issue(1'b0, 1'b1, LEN_LEFT, 32'h0000_0001, 32'h1122_3344, 0);
    issue(1'b0, 1'b1, LEN_RIGHT, 32'h0000_0001, 32'h5566_7788, 0);
    issue(1'b1, 1'b0, LEN_WORD, 32'h0000_0004, 32'd0, 0);
    issue(1'b1, 1'b0, LEN_HALF, 32'h0000_0003, 32'd0, 0);
    issue(1'b1, 1'b0, LEN_WORD, 32'h0000_0010, 32'd0, 2);
    issue(1'b0, 1'b1, LEN_WORD, 32'h0000_0014, 32'hCAFE_F00D, 3);
    issue(1'b1, 1'b0, LEN_WORD, 32'h0000_0014, 32'd0, 0);

    // reset in the middle of a write, then a normal read of the same word
    mem_access_write = 1'b1; mem_access_size = LEN_WORD;
    mem_access_addr = 32'h0000_0020; mem_access_data_out = 32'h0BAD_C0DE;
    apply_write(8, 4'b0000, 32'h0BAD_C0DE);
    @(posedge clk); #1 mem_access_write = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    model_data = 32'd0;
    #3 check_reset_vals("midreset");
    @(posedge clk); #1;
    issue(1'b1, 1'b0, LEN_WORD, 32'h0000_0020, 32'd0, 0);

    for (int t = 0; t < 80; t++) begin
      sel = $urandom_range(0, 9);
      sz = 3'($urandom_range(0, 4));
      a = ($urandom & 32'hFFC0_0000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      rd = (sel < 4 || sel >= 7) ? 1 : 0;
      wr = (sel >= 4 && sel <= 7) ? 1 : 0;
      fm = 0;
      if (sel == 8) fm = 1;
      else if (sel == 9) fm = 2;
      else if (wr == 1 && $urandom_range(0, 3) == 0) fm = 3;
      issue(rd[0], wr[0], sz, a, $urandom, fm);
    end

    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
